encoder_channel: RTL and testbench

- Upstream front-end for one colour channel of the RGB mixer: takes raw rotary-encoder pins A/B straight from the pads, synchronises and debounces them, and decodes quadrature.
- Maintains a WIDTH-bit level register that feeds the channel's PWM generator.
- One instance per encoder (three in the mixer).
- Also accepts a synchronous load for setting a level from firmware.

---
 rtl/encoder_pkg.sv | 30 +++
 rtl/pin_debounce.sv | 52 +++++
 rtl/encoder_channel.sv | 150 +++++++++++++++
 tb/tb_encoder_channel.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared quadrature encodings, direction type and transition classifier for encoder_channel.
package encoder_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q10 = 2'b10;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q01 = 2'b01;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_CW,
    DIR_CCW,
    DIR_ERR
  } dir_e;

  // Classify a debounced {a,b} transition; CW order is 00->10->11->01->00.
  function automatic dir_e next_dir(input logic [1:0] prev, input logic [1:0] curr);
    logic [1:0] cw_next;
    case (prev)
      Q00:     cw_next = Q10;
      Q10:     cw_next = Q11;
      Q11:     cw_next = Q01;
      default: cw_next = Q00;
    endcase
    if (curr == prev) return DIR_NONE;
    if ((curr ^ prev) == 2'b11) return DIR_ERR;
    return (curr == cw_next) ? DIR_CW : DIR_CCW;
  endfunction

endpackage

// File: rtl/pin_debounce.sv
// Two-flop synchroniser plus strobe-sampled stability counter for one raw encoder pin.
module pin_debounce #(
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  input  logic pin_raw,
  output logic pin_db
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_SAMPLES + 1);

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // A differing sample on the last needed strobe accepts the new value directly.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (strobe) begin
      if (sync2_q != db_q) begin
        if (cnt_q == CntW'(DEBOUNCE_SAMPLES - 1)) begin
          db_d  = sync2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign pin_db = db_q;

endmodule

// File: rtl/encoder_channel.sv
// Rotary-encoder front-end for one colour channel: debounce, quadrature decode, detent, level.
// Define ENCODER_WRAP_EN to make the level wrap instead of saturating.
module encoder_channel
  import encoder_pkg::*;
#(
  parameter int unsigned     WIDTH            = 8,
  parameter int unsigned     PRESCALE         = 1000,
  parameter int unsigned     DEBOUNCE_SAMPLES = 4,
  parameter int unsigned     STEPS_PER_DETENT = 4,
  parameter logic [WIDTH-1:0] INIT_VALUE      = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] level,
  output logic             step_up,
  output logic             step_down,
  output logic             quad_err
);

  localparam int unsigned       PreW   = $clog2(PRESCALE);
  localparam logic signed [3:0] SubMax = 4'(STEPS_PER_DETENT - 1);
  localparam logic signed [3:0] SubMin = -SubMax;

  logic [PreW-1:0]   pre_q, pre_d;
  logic              strobe, strobe_q;
  logic              db_a, db_b;
  logic [1:0]        ab, prev_q, prev_d;
  logic signed [3:0] sub_q, sub_d;
  logic [WIDTH-1:0]  level_q, level_d;
  logic              up_q, up_d, dn_q, dn_d, err_q, err_d;
  logic              up_evt, dn_evt;
  dir_e              dir;

  assign strobe = (pre_q == PreW'(PRESCALE - 1));
  assign pre_d  = strobe ? '0 : pre_q + PreW'(1);

  pin_debounce #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_deb_a (
    .clk    (clk),
    .reset_n(reset_n),
    .strobe (strobe),
    .pin_raw(enc_a),
    .pin_db (db_a)
  );

  pin_debounce #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_deb_b (
    .clk    (clk),
    .reset_n(reset_n),
    .strobe (strobe),
    .pin_raw(enc_b),
    .pin_db (db_b)
  );

  assign ab = {db_a, db_b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q    <= '0;
      strobe_q <= 1'b0;
      prev_q   <= Q00;
      sub_q    <= '0;
      level_q  <= INIT_VALUE;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      strobe_q <= strobe;
      prev_q   <= prev_d;
      sub_q    <= sub_d;
      level_q  <= level_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      err_q    <= err_d;
    end
  end

  // Decode runs the cycle after the strobe so it sees the freshly debounced pins.
  always_comb begin
    dir    = DIR_NONE;
    prev_d = prev_q;
    sub_d  = sub_q;
    err_d  = 1'b0;
    up_evt = 1'b0;
    dn_evt = 1'b0;
    if (strobe_q) begin
      dir    = next_dir(prev_q, ab);
      prev_d = ab;
    end
    case (dir)
      DIR_CW: begin
        if (sub_q == SubMax) begin
          up_evt = 1'b1;
          sub_d  = '0;
        end else begin
          sub_d = sub_q + 4'sd1;
        end
      end
      DIR_CCW: begin
        if (sub_q == SubMin) begin
          dn_evt = 1'b1;
          sub_d  = '0;
        end else begin
          sub_d = sub_q - 4'sd1;
        end
      end
      DIR_ERR: begin
        err_d = 1'b1;
        sub_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    level_d = level_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    if (load_en) begin
      level_d = load_value;
    end else if (up_evt) begin
      up_d = 1'b1;
`ifdef ENCODER_WRAP_EN
      level_d = level_q + WIDTH'(1);
`else
      if (level_q != '1) level_d = level_q + WIDTH'(1);
`endif
    end else if (dn_evt) begin
      dn_d = 1'b1;
`ifdef ENCODER_WRAP_EN
      level_d = level_q - WIDTH'(1);
`else
      if (level_q != '0) level_d = level_q - WIDTH'(1);
`endif
    end
  end

  assign level     = level_q;
  assign step_up   = up_q;
  assign step_down = dn_q;
  assign quad_err  = err_q;

endmodule

// File: tb/tb_encoder_channel.sv
// Randomised and directed bench for encoder_channel against a cycle-level behavioural model.
module tb_encoder_channel;

  localparam int W    = 8;
  localparam int P    = 4;
  localparam int N    = 2;
  localparam int S    = 4;
  localparam int MAXL = (1 << W) - 1;

  logic         clk, reset_n, enc_a, enc_b, load_en;
  logic [W-1:0] load_value, level;
  logic         step_up, step_down, quad_err;

  encoder_channel #(
    .WIDTH           (W),
    .PRESCALE        (P),
    .DEBOUNCE_SAMPLES(N),
    .STEPS_PER_DETENT(S),
    .INIT_VALUE      ('0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .load_en   (load_en),
    .load_value(load_value),
    .level     (level),
    .step_up   (step_up),
    .step_down (step_down),
    .quad_err  (quad_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cnt_up = 0, cnt_dn = 0, cnt_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Angular position of a pin pair along the CW sequence 00,10,11,01.
  int pos_of[4] = '{0, 3, 1, 2};
  int ab_of[4]  = '{0, 2, 3, 1};

  // Behavioural model, indexed [0]=a, [1]=b.
  int m_s1[2], m_s2[2], m_db[2], m_cnt[2];
  int m_pre, m_strq, m_prev, m_sub, m_lvl, m_up, m_dn, m_err;

  function automatic int sat_or_wrap(input int v);
`ifdef ENCODER_WRAP_EN
    return (v + MAXL + 1) % (MAXL + 1);
`else
    return (v < 0) ? 0 : (v > MAXL) ? MAXL : v;
`endif
  endfunction

  task automatic m_reset();
    for (int p = 0; p < 2; p++) begin
      m_s1[p] = 0; m_s2[p] = 0; m_db[p] = 0; m_cnt[p] = 0;
    end
    m_pre = 0; m_strq = 0; m_prev = 0; m_sub = 0;
    m_lvl = 0; m_up = 0; m_dn = 0; m_err = 0;
  endtask

  function automatic int m_delta();
    return (pos_of[m_db[0] * 2 + m_db[1]] - m_prev + 4) % 4;
  endfunction

  function automatic bit m_step_next();
    int d;
    if (m_strq == 0) return 1'b0;
    d = m_delta();
    return (d == 1 && m_sub + 1 == S) || (d == 3 && m_sub - 1 == -S);
  endfunction

  task automatic m_step();
    int d, up, dn, strobe, raw;
    up = 0; dn = 0; m_err = 0;
    if (m_strq != 0) begin
      d = m_delta();
      m_prev = pos_of[m_db[0] * 2 + m_db[1]];
      if (d == 1) begin
        m_sub++;
        if (m_sub == S) begin up = 1; m_sub = 0; end
      end else if (d == 3) begin
        m_sub--;
        if (m_sub == -S) begin dn = 1; m_sub = 0; end
      end else if (d == 2) begin
        m_err = 1; m_sub = 0;
      end
    end
    m_up = 0; m_dn = 0;
    if (load_en) m_lvl = int'(load_value);
    else if (up != 0) begin m_up = 1; m_lvl = sat_or_wrap(m_lvl + 1); end
    else if (dn != 0) begin m_dn = 1; m_lvl = sat_or_wrap(m_lvl - 1); end
    strobe = (m_pre == P - 1) ? 1 : 0;
    for (int p = 0; p < 2; p++) begin
      if (strobe != 0) begin
        if (m_s2[p] != m_db[p]) begin
          m_cnt[p]++;
          if (m_cnt[p] == N) begin m_db[p] = m_s2[p]; m_cnt[p] = 0; end
        end else m_cnt[p] = 0;
      end
      raw = (p == 0) ? int'(enc_a) : int'(enc_b);
      m_s2[p] = m_s1[p];
      m_s1[p] = raw;
    end
    m_pre  = (m_pre + 1) % P;
    m_strq = strobe;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  // Compare process: every cycle, #1 after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        chk("level_rst", int'(level), 0);
        chk("pulses_rst", int'(step_up) + int'(step_down) + int'(quad_err), 0);
      end else begin
        chk("level", int'(level), m_lvl);
        chk("step_up", int'(step_up), m_up);
        chk("step_down", int'(step_down), m_dn);
        chk("quad_err", int'(quad_err), m_err);
      end
      chk("pulse_excl", int'(int'(step_up) + int'(step_down) + int'(quad_err) > 1), 0);
      cnt_up  += int'(step_up);
      cnt_dn  += int'(step_down);
      cnt_err += int'(quad_err);
    end
  end

  task automatic hold(input logic a, input logic b, input int n);
    enc_a = a;
    enc_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int v);
    load_en    = 1'b1;
    load_value = W'(v);
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
  endtask

  // Asynchronous reset between edges, pins parked at 00.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_level", int'(level), 0);
    chk("async_rst_up", int'(step_up), 0);
    enc_a = 1'b0;
    enc_b = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  int u0, d0, e0, r, tp, np;
  bit seen;

  initial begin
    reset_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0; load_en = 1'b0; load_value = '0;
    repeat (3) @(negedge clk);
    chk("reset_level", int'(level), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // One CW detent; half a cycle must not step.
    u0 = cnt_up;
    hold(1, 0, 20); hold(1, 1, 20);
    chk("half_cycle_no_step", cnt_up - u0, 0);
    hold(0, 1, 20); hold(0, 0, 20);
    chk("cw_detent_steps", cnt_up - u0, 1);
    chk("cw_detent_level", int'(level), 1);

    // Illegal 00->11 then four CW edges.
    e0 = cnt_err; u0 = cnt_up;
    hold(1, 1, 20);
    chk("illegal_err", cnt_err - e0, 1);
    chk("illegal_level", int'(level), 1);
    hold(0, 1, 20); hold(0, 0, 20); hold(1, 0, 20);
    chk("after_err_3_edges", cnt_up - u0, 0);
    hold(1, 1, 20);
    chk("after_err_4_edges", cnt_up - u0, 1);
    chk("after_err_level", int'(level), 2);

    // Reset mid-operation at level 37 with a partial sub-step pending.
    do_load(37);
    chk("load_37", int'(level), 37);
    hold(0, 1, 20);
    do_reset();
    u0 = cnt_up;
    hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20);
    chk("post_rst_3_edges", cnt_up - u0, 0);
    hold(0, 0, 20);
    chk("post_rst_4_edges", cnt_up - u0, 1);

    // Saturation / wrap at both ends.
    do_load(255);
    u0 = cnt_up;
    hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20); hold(0, 0, 20);
    chk("top_step_pulse", cnt_up - u0, 1);
`ifdef ENCODER_WRAP_EN
    chk("top_level", int'(level), 0);
`else
    chk("top_level", int'(level), 255);
`endif
    do_load(0);
    d0 = cnt_dn;
    hold(0, 1, 20); hold(1, 1, 20); hold(1, 0, 20); hold(0, 0, 20);
    chk("bottom_step_pulse", cnt_dn - d0, 1);
`ifdef ENCODER_WRAP_EN
    chk("bottom_level", int'(level), 255);
`else
    chk("bottom_level", int'(level), 0);
`endif

    // Load colliding with a step: load wins, no pulse.
    u0 = cnt_up;
    hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20);
    enc_a = 1'b0; enc_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (m_step_next()) seen = 1'b1;
    end
    chk("collision_step_found", int'(seen), 1);
    do_load(100);
    repeat (4) @(negedge clk);
    chk("collision_level", int'(level), 100);
    chk("collision_no_pulse", cnt_up - u0, 0);

    // Bounce of one strobe period is rejected; three strobes are accepted.
    u0 = cnt_up; d0 = cnt_dn; e0 = cnt_err;
    hold(1, 0, P); hold(0, 0, 20);
    chk("bounce_level", int'(level), 100);
    chk("bounce_pulses", (cnt_up - u0) + (cnt_dn - d0) + (cnt_err - e0), 0);
    hold(1, 0, 3 * P); hold(0, 1, 20);
    chk("accepted_then_err", cnt_err - e0, 1);

    // Randomised walk, glitches, illegal jumps and loads.
    for (int i = 0; i < 120; i++) begin
      r  = $urandom_range(0, 99);
      tp = pos_of[{30'd0, enc_a, enc_b}];
      if (r < 60) begin
        np = (tp + (($urandom_range(0, 3) != 0) ? 1 : 3)) % 4;
        hold(ab_of[np][1], ab_of[np][0], $urandom_range(2, 30));
      end else if (r < 70) begin
        hold(~enc_a, ~enc_b, 20);
      end else if (r < 85) begin
        load_en    = 1'b1;
        load_value = W'($urandom);
        @(negedge clk);
        load_en = 1'b0;
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end else begin
        hold(~enc_a, enc_b, $urandom_range(1, 6));
        hold(~enc_a, enc_b, $urandom_range(5, 20));
      end
    end
    repeat (30) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
